grf: RTL

GRF -- requirements
Module: grf

---
 rtl/grf.sv | 112 +++++++++++
 1 files changed

// File: rtl/grf.sv
// ---------------------------------------------------------------------------
// grf -- 32 x 32-bit general register file with write trace.
//
// Purpose:
//   Two combinational read ports and one synchronous write port. Register 0
//   is hardwired to zero. BYPASS can forward the write data to the read ports
//   in the same cycle the write is presented. Each committed write is reported
//   one cycle later on the trace outputs, and write_count counts the committed
//   writes.
//
// Parameters:
//   BYPASS      1 = forward WD to RD1/RD2 on an address match, 0 = no forward
//   CNT_W       width of write_count
//
// Ports:
//   clk         clock; all state updates on its rising edge
//   reset       synchronous active-high reset
//   WE          write enable
//   A1, A2      read addresses (rs, rt)
//   A3          write address
//   WD          write data
//   PC          PC of the writing instruction (trace only)
//   RD1, RD2    read data for A1 and A2
//   trace_valid one-cycle pulse marking a committed write
//   trace_pc    PC of the committed write
//   trace_reg   register number of the committed write
//   trace_data  data of the committed write
//   write_count committed writes since reset (wraps)
// ---------------------------------------------------------------------------
module grf #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WE,
    input  logic [4:0]       A1,
    input  logic [4:0]       A2,
    input  logic [4:0]       A3,
    input  logic [31:0]      WD,
    input  logic [31:0]      PC,
    output logic [31:0]      RD1,
    output logic [31:0]      RD2,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_reg,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] write_count
);

    logic [31:0]      r_regs [32];
    logic             r_trace_valid;
    logic [31:0]      r_trace_pc;
    logic [4:0]       r_trace_reg;
    logic [31:0]      r_trace_data;
    logic [CNT_W-1:0] r_write_count;

    // A write to register 0 is dropped entirely: no storage, trace or count.
    logic w_commit;
    assign w_commit = WE && (A3 != 5'd0);

    // Read one port. The forward path is independent of reset so the
    // matching read still sees WD while reset is held.
    function automatic logic [31:0] read_port(
        input logic [4:0]  addr,
        input logic        commit,
        input logic [4:0]  waddr,
        input logic [31:0] wdata,
        input logic [31:0] stored
    );
        logic [31:0] value;
        value = stored;
        if (addr == 5'd0)
            value = 32'd0;
        else if ((BYPASS != 0) && commit && (addr == waddr))
            value = wdata;
        return value;
    endfunction

    always_comb begin
        RD1 = read_port(A1, w_commit, A3, WD, r_regs[A1]);
        RD2 = read_port(A2, w_commit, A3, WD, r_regs[A2]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'd0;
            r_trace_valid <= 1'b0;
            r_trace_pc    <= 32'd0;
            r_trace_reg   <= 5'd0;
            r_trace_data  <= 32'd0;
            r_write_count <= '0;
        end else begin
            r_trace_valid <= w_commit;
            if (w_commit) begin
                r_regs[A3]    <= WD;
                r_trace_pc    <= PC;
                r_trace_reg   <= A3;
                r_trace_data  <= WD;
                r_write_count <= r_write_count + CNT_W'(1);
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_pc    = r_trace_pc;
    assign trace_reg   = r_trace_reg;
    assign trace_data  = r_trace_data;
    assign write_count = r_write_count;

endmodule
